// File: rtl/abro_input_conditioner_if.sv
// Bundle of the raw button inputs and the conditioned A/B levels and press pulses.
// The master drives the raw buttons; the slave is the conditioner.
interface abro_input_conditioner_if;
  logic a_raw;
  logic b_raw;
  logic A;
  logic B;
  logic a_rise;
  logic b_rise;

  modport master (output a_raw, b_raw, input A, B, a_rise, b_rise);
  modport slave  (input a_raw, b_raw, output A, B, a_rise, b_rise);
endinterface

// File: rtl/abro_input_conditioner.sv
// Synchronizes and debounces the raw A/B buttons into clean levels and
// one-cycle press pulses for abro_state_machine. Channels are independent.
module abro_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  abro_input_conditioner_if.slave   io
);

  localparam int unsigned CH = 2;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CH-1:0]          raw;
  logic [SYNC_STAGES-1:0] sync_q  [CH];
  logic [SYNC_STAGES-1:0] sync_d  [CH];
  logic [CW-1:0]          cnt_q   [CH];
  logic [CW-1:0]          cnt_d   [CH];
  logic [CH-1:0]          clean_q, clean_d;
  logic [CH-1:0]          rise_q,  rise_d;

  assign raw = {io.b_raw, io.a_raw};

  // Per channel: shift the synchronizer, count consecutive disagreeing cycles,
  // accept the new level once it has persisted DEBOUNCE_CYCLES edges.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    for (int ch = 0; ch < CH; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      cnt_d[ch]  = cnt_q[ch];
      if (sync_q[ch][SYNC_STAGES-1] == clean_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        clean_d[ch] = sync_q[ch][SYNC_STAGES-1];
        cnt_d[ch]   = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CW'(1);
      end
      rise_d[ch] = ~clean_q[ch] & clean_d[ch];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CH; ch++) begin
        sync_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      clean_q <= '0;
      rise_q  <= '0;
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        sync_q[ch] <= sync_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
      end
      clean_q <= clean_d;
      rise_q  <= rise_d;
    end
  end

  assign io.A      = clean_q[0];
  assign io.B      = clean_q[1];
  assign io.a_rise = rise_q[0];
  assign io.b_rise = rise_q[1];

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Bench for abro_input_conditioner: a default build and a DEBOUNCE_CYCLES=1 build
// share the same stimulus and are checked against a run-length reference model.
module tb_abro_input_conditioner;

  localparam int unsigned DB0 = 4;
  localparam int unsigned DB1 = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  abro_input_conditioner_if if0 ();
  abro_input_conditioner_if if1 ();

  abro_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB0)) dut0 (
    .clk(clk), .reset_n(reset_n), .io(if0));
  abro_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB1)) dut1 (
    .clk(clk), .reset_n(reset_n), .io(if1));

  // Model: a 2-edge delay line per channel, then run length of disagreement.
  logic [1:0] dly [2];
  int         run   [2][2];
  logic       clean [2][2];
  logic       rise  [2][2];

  function automatic int dbv(input int d);
    return (d == 0) ? int'(DB0) : int'(DB1);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) dly[ch] = 2'b00;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 2; ch++) begin
        run[d][ch] = 0; clean[d][ch] = 1'b0; rise[d][ch] = 1'b0;
      end
  endtask

  task automatic model_edge(input logic a, input logic b);
    logic [1:0] r;
    logic s;
    r = {b, a};
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 2; ch++) begin
        s = dly[ch][1];
        rise[d][ch] = 1'b0;
        if (s !== clean[d][ch]) begin
          run[d][ch]++;
          if (run[d][ch] >= dbv(d)) begin
            clean[d][ch] = s;
            rise[d][ch]  = s;
            run[d][ch]   = 0;
          end
        end else begin
          run[d][ch] = 0;
        end
      end
    for (int ch = 0; ch < 2; ch++) dly[ch] = {dly[ch][0], r[ch]};
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/A0"},  if0.A,      clean[0][0]);
    chk({tag, "/B0"},  if0.B,      clean[0][1]);
    chk({tag, "/ar0"}, if0.a_rise, rise[0][0]);
    chk({tag, "/br0"}, if0.b_rise, rise[0][1]);
    chk({tag, "/A1"},  if1.A,      clean[1][0]);
    chk({tag, "/B1"},  if1.B,      clean[1][1]);
    chk({tag, "/ar1"}, if1.a_rise, rise[1][0]);
    chk({tag, "/br1"}, if1.b_rise, rise[1][1]);
  endtask

  task automatic drive(input logic a, input logic b);
    if0.a_raw = a; if0.b_raw = b;
    if1.a_raw = a; if1.b_raw = b;
  endtask

  // One cycle: inputs change on the falling edge, outputs checked 1 ns after rising edge.
  task automatic step(input logic a, input logic b, input logic rn, input string tag);
    @(negedge clk);
    reset_n = rn;
    drive(a, b);
    @(posedge clk);
    if (reset_n) model_edge(a, b);
    else         model_reset();
    #1;
    check_all(tag);
  endtask

  initial begin
    int first;
    int highs;
    logic [9:0] bounce;
    logic lvl_a, lvl_b;
    int hold_a, hold_b;

    // 1. Reset with raw inputs high; both channels accept on the 6th edge after release.
    drive(1'b1, 1'b1);
    model_reset();
    #1 check_all("t1_rst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "t1_hold");
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b1, "t1_rel");
      if (i == 5) chk("t1_A_pre6", if0.A, 1'b0);
      if (i == 6) begin
        chk("t1_A6", if0.A, 1'b1);     chk("t1_B6", if0.B, 1'b1);
        chk("t1_ar6", if0.a_rise, 1'b1); chk("t1_br6", if0.b_rise, 1'b1);
      end
      if (i == 7) begin
        chk("t1_ar7", if0.a_rise, 1'b0); chk("t1_br7", if0.b_rise, 1'b0);
      end
    end

    // 2. Clean press held 10 cycles, then release.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, "t2_idle");
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b1, "t2_press");
      if (first == 0 && if0.A) first = i;
    end
    chk("t2_rise_edge_is_6", 1'(first == 6), 1'b1);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b1, "t2_release");
      if (first == 0 && !if0.A) first = i;
      chk("t2_no_rise_on_fall", if0.a_rise, 1'b0);
    end
    chk("t2_fall_edge_is_6", 1'(first == 6), 1'b1);

    // 3. Bounce: 1,1,1,0,1,1,1,1,1,1 then held high.
    bounce = 10'b1111110111;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      step((i < 10) ? bounce[i] : 1'b1, 1'b0, 1'b1, "t3_bounce");
      if (if0.a_rise) highs++;
    end
    chk("t3_single_pulse", 1'(highs == 1), 1'b1);

    // 4. Simultaneous press on both channels.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, "t4_idle");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, "t4_both");

    // 5. Reset dropped mid-count with cnt at 2.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, "t5_idle");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, "t5_count");
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all("t5_async");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, "t5_hold");
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b1, "t5_rel");
      if (first == 0 && if0.a_rise) first = i;
    end
    chk("t5_rise_edge_is_6", 1'(first == 6), 1'b1);

    // 6. One-cycle raw pulse: only the DEBOUNCE_CYCLES=1 build passes it.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, "t6_idle");
    highs = 0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step((i == 1) ? 1'b1 : 1'b0, 1'b0, 1'b1, "t6_pulse");
      if (if1.A) highs++;
      if (if1.A && if1.a_rise && first == 0) first = i;
      chk("t6_db4_blocks", if0.A, 1'b0);
    end
    chk("t6_one_high_cycle", 1'(highs == 1), 1'b1);
    chk("t6_high_on_edge3", 1'(first == 3), 1'b1);

    // Random bouncy levels with independent hold lengths per channel.
    lvl_a = 1'b0; lvl_b = 1'b0; hold_a = 0; hold_b = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold_a == 0) begin lvl_a = 1'($urandom); hold_a = int'($urandom_range(1, 8)); end
      if (hold_b == 0) begin lvl_b = 1'($urandom); hold_b = int'($urandom_range(1, 8)); end
      hold_a--; hold_b--;
      step(lvl_a, lvl_b, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
